// File: rtl/reload_down_timer.sv
// Reloadable down-counter timer with one-shot and auto-reload (periodic) modes.
// A reload register is written by load_i; start_i copies it into the count.
// The count decrements once per enabled tick. Reaching the terminal event
// either stops the timer in DONE or reloads it and keeps it running.
module reload_down_timer #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 load_i,
    input  logic [BUS_WIDTH-1:0] data_i,
    input  logic                 e_i,
    input  logic                 auto_i,
    input  logic                 ack_i,
    output logic [BUS_WIDTH-1:0] count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tc_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [BUS_WIDTH-1:0] reload_q;
    logic [BUS_WIDTH-1:0] reload_d;
    logic [BUS_WIDTH-1:0] count_d;
    logic [BUS_WIDTH-1:0] eff_reload;
    logic                 tc_d;

    // A load in the same cycle as a start or reload takes effect immediately.
    assign eff_reload = load_i ? data_i : reload_q;

    // Next-state, next-count and terminal-count decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_o;
        reload_d = load_i ? data_i : reload_q;
        tc_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (eff_reload == '0) begin
                        state_d = ST_DONE;
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        count_d = eff_reload;
                    end
                end else if (load_i) begin
                    count_d = data_i;
                end
            end

            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (e_i) begin
                    if (count_o <= BUS_WIDTH'(1)) begin
                        tc_d = 1'b1;
                        // A zero reload cannot sustain a period, so it ends the run.
                        if (auto_i && (eff_reload != '0)) begin
                            count_d = eff_reload;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_o - BUS_WIDTH'(1);
                    end
                end
            end

            ST_DONE: begin
                count_d = '0;
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, reload and registered outputs; reset suppresses any pending pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            count_o  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            tc_o     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count_o  <= count_d;
            busy_o   <= (state_d == ST_RUN);
            done_o   <= (state_d == ST_DONE);
            tc_o     <= tc_d;
        end
    end

endmodule

// File: tb/tb_reload_down_timer.sv
// Scoreboard bench for reload_down_timer: each driven cycle pushes the
// expected outputs, the sampled outputs are queued, and each scenario
// drains and compares both queues.
module tb_reload_down_timer;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
        logic         tc;
    } obs_t;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic         load_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         e_i = 1'b0;
    logic         auto_i = 1'b0;
    logic         ack_i = 1'b0;
    logic [W-1:0] count_o;
    logic         busy_o;
    logic         done_o;
    logic         tc_o;

    int tests_run    = 0;
    int tests_failed = 0;

    obs_t exp_q[$];
    obs_t obs_q[$];

    reload_down_timer #(.BUS_WIDTH(W)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .start_i (start_i),
        .stop_i  (stop_i),
        .load_i  (load_i),
        .data_i  (data_i),
        .e_i     (e_i),
        .auto_i  (auto_i),
        .ack_i   (ack_i),
        .count_o (count_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .tc_o    (tc_o)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of inputs, record the expectation, sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic s, input logic p, input logic l,
                       input logic [W-1:0] d, input logic e, input logic a, input logic k,
                       input logic [W-1:0] ec, input logic eb, input logic ed, input logic et);
        obs_t ex;
        obs_t ob;
        Rst = r; start_i = s; stop_i = p; load_i = l; data_i = d;
        e_i = e; auto_i = a; ack_i = k;
        ex.count = ec; ex.busy = eb; ex.done = ed; ex.tc = et;
        exp_q.push_back(ex);
        @(posedge Clk);
        #1;
        ob.count = count_o; ob.busy = busy_o; ob.done = done_o; ob.tc = tc_o;
        obs_q.push_back(ob);
    endtask

    task automatic test_reset();
        obs_t e, o;
        int n = 0;
        cyc(1, 1, 0, 1, 8'd9, 1, 0, 0,  8'd0, 0, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 0, 0,  8'd0, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 1,  8'd0, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    task automatic test_one_shot();
        obs_t e, o;
        int n = 0;
        cyc(0, 0, 0, 1, 8'd5, 0, 0, 0,  8'd5, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 1, 0, 0,  8'd5, 1, 0, 0);
        for (int c = 4; c >= 1; c--) cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  W'(c), 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 1, 1);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 1, 0);
        cyc(0, 1, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 1, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 0, 1,  8'd0, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL one_shot[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    task automatic test_auto_reload();
        obs_t e, o;
        int n = 0;
        cyc(0, 0, 0, 1, 8'd3, 0, 1, 0,  8'd3, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 1, 1, 0,  8'd3, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            // auto_i only matters on the terminal tick
            cyc(0, 0, 0, 0, 8'd0, 1, (k == 1) ? 1'b0 : 1'b1, 0,  8'd2, 1, 0, 0);
            cyc(0, 0, 0, 0, 8'd0, 1, (k == 1) ? 1'b0 : 1'b1, 0,  8'd1, 1, 0, 0);
            cyc(0, 0, 0, 0, 8'd0, 1, 1, 0,  8'd3, 1, 0, 1);
        end
        cyc(0, 0, 0, 0, 8'd0, 1, 1, 0,  8'd2, 1, 0, 0);
        cyc(0, 0, 1, 0, 8'd0, 1, 1, 0,  8'd2, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL auto_reload[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    task automatic test_gated_stop();
        obs_t e, o;
        int n = 0;
        cyc(0, 0, 0, 1, 8'd4, 0, 0, 0,  8'd4, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 0, 0,  8'd4, 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd3, 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 0, 0, 0,  8'd3, 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd2, 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 0, 0, 0,  8'd2, 1, 0, 0);
        cyc(0, 0, 1, 0, 8'd0, 1, 0, 0,  8'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 1,  8'd2, 0, 0, 0);
        // stop beats a same-cycle terminal tick
        cyc(0, 0, 0, 1, 8'd1, 0, 0, 0,  8'd1, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 0, 0,  8'd1, 1, 0, 0);
        cyc(0, 0, 1, 0, 8'd0, 1, 1, 0,  8'd1, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 0, 0, 0,  8'd1, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL gated_stop[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    task automatic test_zero_reload();
        obs_t e, o;
        int n = 0;
        cyc(0, 0, 0, 1, 8'd0, 0, 0, 0,  8'd0, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 1, 1);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 1, 0);
        cyc(0, 0, 0, 1, 8'd6, 0, 0, 0,  8'd0, 0, 1, 0);
        cyc(0, 0, 0, 0, 8'd0, 0, 0, 1,  8'd0, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 0, 0,  8'd6, 1, 0, 0);
        cyc(0, 0, 1, 0, 8'd0, 0, 0, 0,  8'd6, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'd0, 0, 0, 0,  8'd0, 0, 0, 0);
        cyc(0, 1, 0, 1, 8'd7, 0, 0, 0,  8'd7, 1, 0, 0);
        cyc(0, 0, 1, 0, 8'd0, 0, 0, 0,  8'd7, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL zero_reload[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    task automatic test_load_in_run();
        obs_t e, o;
        int n = 0;
        cyc(0, 0, 0, 1, 8'd5, 0, 1, 0,  8'd5, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 1, 0,  8'd5, 1, 0, 0);
        cyc(0, 0, 0, 1, 8'd2, 0, 1, 0,  8'd5, 1, 0, 0);
        for (int c = 4; c >= 1; c--) cyc(0, 0, 0, 0, 8'd0, 1, 1, 0,  W'(c), 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 1, 0,  8'd2, 1, 0, 1);
        cyc(0, 0, 0, 0, 8'd0, 1, 1, 0,  8'd1, 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 1, 0,  8'd2, 1, 0, 1);
        cyc(0, 0, 1, 0, 8'd0, 1, 1, 0,  8'd2, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL load_in_run[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    task automatic test_rst_terminal();
        obs_t e, o;
        int n = 0;
        cyc(0, 0, 0, 1, 8'd2, 0, 0, 0,  8'd2, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 1, 0, 0,  8'd2, 1, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd1, 1, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 0, 0);
        // reload register was cleared by reset, so start finishes immediately
        cyc(0, 1, 0, 0, 8'd0, 1, 0, 0,  8'd0, 0, 1, 1);
        cyc(0, 0, 0, 0, 8'd0, 0, 0, 0,  8'd0, 0, 1, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 0, 0,  8'd0, 0, 0, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rst_terminal[%0d] got count=%0d busy=%b done=%b tc=%b want count=%0d busy=%b done=%b tc=%b",
                         n, o.count, o.busy, o.done, o.tc, e.count, e.busy, e.done, e.tc);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_gated_stop();
        test_zero_reload();
        test_load_in_run();
        test_rst_terminal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
